dmem_arbiter: RTL

Single-port access arbiter and sequencer for the byte-addressed, big-endian `Data_Memory` (512 bytes). It sits between the MEM stage of the pipeline and a secondary loader/debug port, and drives the memory's `A_in`, `DI`, `Size`, `RW`, `E` and `SE` inputs. The pipeline has priority, and a starvation counter guarantees the loader forward progress. The block also checks alignment and size legality so that illegal accesses never reach the memory.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Pipeline/loader arbiter for the 512-byte big-endian Data_Memory,
//            with starvation-bounded loader grant and alignment checking.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid,
    input  logic        p_rw,
    input  logic [1:0]  p_size,
    input  logic        p_se,
    input  logic [8:0]  p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_stall,
    output logic        p_err,
    input  logic        l_req,
    input  logic        l_rw,
    input  logic [1:0]  l_size,
    input  logic        l_se,
    input  logic [8:0]  l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_ack,
    output logic [31:0] l_rdata,
    output logic        l_err,
    output logic [8:0]  m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    output logic        m_rw,
    output logic        m_e,
    output logic        m_se,
    input  logic [31:0] m_rdata
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    localparam logic [2:0] c_STARVE_LIMIT = 3'(STARVE_LIMIT);

    state_t      r_state;
    logic [2:0]  r_starve_cnt;
    logic        r_l_ack;
    logic        r_l_err;
    logic [31:0] r_l_rdata;

    logic        w_l_gnt;
    logic        w_p_gnt;
    logic        w_legal;

    function automatic logic f_legal(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b00:   f_legal = 1'b1;
            2'b01:   f_legal = (lsb[0] == 1'b0);
            2'b10:   f_legal = (lsb == 2'b00);
            default: f_legal = 1'b0;
        endcase
    endfunction

    // The loader is only ever granted from IDLE; the ACK cycle belongs to the pipeline.
    assign w_l_gnt = (r_state == S_IDLE) && l_req &&
                     (!p_valid || (r_starve_cnt == c_STARVE_LIMIT));
    assign w_p_gnt = p_valid && !w_l_gnt;

    always_comb begin
        m_addr  = p_addr;
        m_wdata = p_wdata;
        m_size  = p_size;
        m_rw    = p_rw;
        m_se    = p_se;
        if (w_l_gnt) begin
            m_addr  = l_addr;
            m_wdata = l_wdata;
            m_size  = l_size;
            m_rw    = l_rw;
            m_se    = l_se;
        end
    end

    assign w_legal = f_legal(m_size, m_addr[1:0]);
    assign m_e     = (w_l_gnt || w_p_gnt) && w_legal && !reset;

    assign p_stall = p_valid && w_l_gnt;
    assign p_err   = p_valid && !p_stall && !w_legal;
    assign p_rdata = (w_p_gnt && w_legal && !p_rw) ? m_rdata : 32'h0;

    assign l_ack   = r_l_ack;
    assign l_err   = r_l_err;
    assign l_rdata = r_l_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 3'd0;
            r_l_ack      <= 1'b0;
            r_l_err      <= 1'b0;
            r_l_rdata    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_l_gnt) begin
                        r_l_rdata    <= (w_legal && !l_rw) ? m_rdata : 32'h0;
                        r_l_err      <= !w_legal;
                        r_l_ack      <= 1'b1;
                        r_starve_cnt <= 3'd0;
                        r_state      <= S_ACK;
                    end else if (l_req) begin
                        if (r_starve_cnt != c_STARVE_LIMIT) begin
                            r_starve_cnt <= r_starve_cnt + 3'd1;
                        end
                    end else begin
                        r_starve_cnt <= 3'd0;
                    end
                end
                S_ACK: begin
                    r_l_ack <= 1'b0;
                    r_l_err <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
